systolic_mac_pe: RTL and testbench

//  - Parametrised output-stationary processing element for the systolic array.
//  - Each cycle it forwards A east and B south through one register stage, each with its own valid bit.
//  - When both inputs are valid it multiply-accumulates them; after k_len products the tile result is emitted.
//  - The result leaves through a valid/ready output buffer, so the array edge can drain results without stalling the data flow.

---
 rtl/systolic_mac_pe_if.sv | 42 ++++
 rtl/systolic_mac_pe.sv | 148 ++++++++++++++
 tb/tb_systolic_mac_pe.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_mac_pe_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mac_pe_if
// Purpose  : Operand forwarding, control and result-handshake bundle for one
//            systolic MAC processing element.
// Revision : 1.0
// ============================================================================
interface systolic_mac_pe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int KLEN_WIDTH = 8
);
    logic                         clear;
    logic [KLEN_WIDTH-1:0]        k_len;
    logic signed [DATA_WIDTH-1:0] a_in;
    logic                         a_in_valid;
    logic signed [DATA_WIDTH-1:0] b_in;
    logic                         b_in_valid;
    logic signed [DATA_WIDTH-1:0] a_out;
    logic                         a_out_valid;
    logic signed [DATA_WIDTH-1:0] b_out;
    logic                         b_out_valid;
    logic signed [ACC_WIDTH-1:0]  c_out;
    logic                         c_valid;
    logic                         c_ready;
    logic                         busy;
    logic                         err_ovf;
    logic                         err_sat;

    modport slave (
        input  clear, k_len, a_in, a_in_valid, b_in, b_in_valid, c_ready,
        output a_out, a_out_valid, b_out, b_out_valid, c_out, c_valid,
               busy, err_ovf, err_sat
    );

    modport master (
        output clear, k_len, a_in, a_in_valid, b_in, b_in_valid, c_ready,
        input  a_out, a_out_valid, b_out, b_out_valid, c_out, c_valid,
               busy, err_ovf, err_sat
    );
endinterface
`default_nettype wire

// File: rtl/systolic_mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mac_pe
// Purpose  : Output-stationary MAC PE; optional clamping accumulator when
//            SYSTOLIC_PE_SATURATE_EN is defined.
// Revision : 1.0
// ============================================================================
module systolic_mac_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int KLEN_WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    systolic_mac_pe_if.slave pe
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t                         r_state, w_state_n;
    logic signed [ACC_WIDTH-1:0]    r_acc, w_acc_n, w_prod, w_sum;
    logic [KLEN_WIDTH-1:0]          r_cnt, w_cnt_n, r_klen, w_klen_n;
    logic [KLEN_WIDTH-1:0]          w_klen_eff, w_cnt_inc;
    logic signed [2*DATA_WIDTH-1:0] w_prod_full;
    logic                           w_beat, w_done;

    logic signed [DATA_WIDTH-1:0]   r_a_out, r_b_out;
    logic                           r_a_out_valid, r_b_out_valid;
    logic signed [ACC_WIDTH-1:0]    r_c_out;
    logic                           r_c_valid, r_err_ovf;

    assign w_beat      = pe.a_in_valid & pe.b_in_valid;
    assign w_prod_full = pe.a_in * pe.b_in;
    assign w_prod      = ACC_WIDTH'(w_prod_full);
    assign w_klen_eff  = (pe.k_len == '0) ? KLEN_WIDTH'(1) : pe.k_len;
    assign w_cnt_inc   = r_cnt + KLEN_WIDTH'(1);

    // The accumulator is always zero in IDLE, so acc+p also yields the first product.
`ifdef SYSTOLIC_PE_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] w_sum_ext;
    logic                      w_sat_hit;
    logic                      r_err_sat;

    assign w_sum_ext = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_prod);
    assign w_sat_hit = w_sum_ext[ACC_WIDTH] != w_sum_ext[ACC_WIDTH-1];
    assign w_sum     = !w_sat_hit ? w_sum_ext[ACC_WIDTH-1:0]
                     : (w_sum_ext[ACC_WIDTH] ? C_ACC_MIN : C_ACC_MAX);

    always_ff @(posedge clk) begin
        if (rst)
            r_err_sat <= 1'b0;
        else if (!pe.clear && w_beat && w_sat_hit)
            r_err_sat <= 1'b1;
    end

    assign pe.err_sat = r_err_sat;
`else
    assign w_sum      = r_acc + w_prod;
    assign pe.err_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_klen  <= '0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_cnt   <= w_cnt_n;
            r_klen  <= w_klen_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_cnt_n   = r_cnt;
        w_klen_n  = r_klen;
        w_done    = 1'b0;
        if (pe.clear) begin
            w_state_n = IDLE;
            w_acc_n   = '0;
            w_cnt_n   = '0;
        end else if (w_beat) begin
            if (r_state == IDLE) begin
                w_klen_n = w_klen_eff;
                w_done   = (w_klen_eff == KLEN_WIDTH'(1));
            end else begin
                w_done   = (w_cnt_inc == r_klen);
            end
            if (w_done) begin
                w_state_n = IDLE;
                w_acc_n   = '0;
                w_cnt_n   = '0;
            end else begin
                w_state_n = ACCUM;
                w_acc_n   = w_sum;
                w_cnt_n   = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_out       <= '0;
            r_b_out       <= '0;
            r_a_out_valid <= 1'b0;
            r_b_out_valid <= 1'b0;
        end else begin
            r_a_out       <= pe.a_in;
            r_b_out       <= pe.b_in;
            r_a_out_valid <= pe.a_in_valid;
            r_b_out_valid <= pe.b_in_valid;
        end
    end

    // Single-entry result buffer: a draining entry can be replaced in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_out   <= '0;
            r_c_valid <= 1'b0;
            r_err_ovf <= 1'b0;
        end else if (w_done) begin
            if (!r_c_valid || pe.c_ready) begin
                r_c_out   <= w_sum;
                r_c_valid <= 1'b1;
            end else begin
                r_err_ovf <= 1'b1;
            end
        end else if (r_c_valid && pe.c_ready) begin
            r_c_valid <= 1'b0;
        end
    end

    assign pe.a_out       = r_a_out;
    assign pe.b_out       = r_b_out;
    assign pe.a_out_valid = r_a_out_valid;
    assign pe.b_out_valid = r_b_out_valid;
    assign pe.c_out       = r_c_out;
    assign pe.c_valid     = r_c_valid;
    assign pe.busy        = (r_state == ACCUM);
    assign pe.err_ovf     = r_err_ovf;
endmodule
`default_nettype wire

// File: tb/tb_systolic_mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_mac_pe
// Purpose  : Directed self-checking bench for systolic_mac_pe (40-bit and
//            32-bit accumulator instances).
// Revision : 1.0
// ============================================================================
module tb_systolic_mac_pe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_mac_pe_if #(.DATA_WIDTH(16), .ACC_WIDTH(40), .KLEN_WIDTH(8)) u_if ();
    systolic_mac_pe_if #(.DATA_WIDTH(16), .ACC_WIDTH(32), .KLEN_WIDTH(8)) u_if32 ();

    systolic_mac_pe #(.DATA_WIDTH(16), .ACC_WIDTH(40), .KLEN_WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .pe  (u_if)
    );

    systolic_mac_pe #(.DATA_WIDTH(16), .ACC_WIDTH(32), .KLEN_WIDTH(8)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .pe  (u_if32)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic bv, input int a, input int b);
        u_if.a_in       = 16'(a);
        u_if.b_in       = 16'(b);
        u_if.a_in_valid = av;
        u_if.b_in_valid = bv;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        u_if.clear = 1'b0;  u_if.k_len = '0;  u_if.c_ready = 1'b1;
        u_if.a_in = 16'sd5; u_if.a_in_valid = 1'b1;
        u_if.b_in = 16'sd3; u_if.b_in_valid = 1'b1;
        u_if32.clear = 1'b0; u_if32.k_len = '0; u_if32.c_ready = 1'b1;
        u_if32.a_in = '0; u_if32.a_in_valid = 1'b0;
        u_if32.b_in = '0; u_if32.b_in_valid = 1'b0;
        step();
        step();
        check("rst_a_out",       u_if.a_out,       0);
        check("rst_a_out_valid", u_if.a_out_valid, 0);
        check("rst_b_out_valid", u_if.b_out_valid, 0);
        check("rst_c_out",       u_if.c_out,       0);
        check("rst_c_valid",     u_if.c_valid,     0);
        check("rst_busy",        u_if.busy,        0);
        check("rst_err_ovf",     u_if.err_ovf,     0);
        check("rst_err_sat",     u_if.err_sat,     0);

        // Forwarding (also a k_len=0 single-product tile)
        rst = 1'b0;
        drive(1'b1, 1'b1, 5, -3);
        check("fwd_a_out",       u_if.a_out,       5);
        check("fwd_b_out",       u_if.b_out,       -3);
        check("fwd_a_out_valid", u_if.a_out_valid, 1);
        check("fwd_b_out_valid", u_if.b_out_valid, 1);
        check("fwd_c_out",       u_if.c_out,       -15);
        idle();
        check("fwd_a_valid_drop", u_if.a_out_valid, 0);
        check("fwd_c_drained",    u_if.c_valid,     0);

        // Dot product, k_len=4
        u_if.k_len = 8'd4;
        drive(1'b1, 1'b1, 1, 2);
        check("dot_busy1",   u_if.busy,    1);
        check("dot_cv1",     u_if.c_valid, 0);
        drive(1'b1, 1'b1, 3, 4);
        drive(1'b1, 1'b1, -5, 6);
        check("dot_busy3",   u_if.busy,    1);
        check("dot_cv3",     u_if.c_valid, 0);
        drive(1'b1, 1'b1, 7, -8);
        check("dot_c_out",   u_if.c_out,   -72);
        check("dot_c_valid", u_if.c_valid, 1);
        check("dot_busy4",   u_if.busy,    0);
        idle();
        check("dot_c_valid_1cyc", u_if.c_valid, 0);

        // One-sided cycles between beats
        u_if.k_len = 8'd3;
        drive(1'b1, 1'b1, 2, 2);
        drive(1'b1, 1'b0, 7, 7);
        check("gap_busy", u_if.busy, 1);
        drive(1'b0, 1'b1, 7, 7);
        drive(1'b1, 1'b1, 2, 2);
        drive(1'b1, 1'b0, 7, 7);
        drive(1'b0, 1'b1, 7, 7);
        check("gap_cv_early", u_if.c_valid, 0);
        drive(1'b1, 1'b1, 2, 2);
        check("gap_c_out",   u_if.c_out,   12);
        check("gap_c_valid", u_if.c_valid, 1);
        u_if.k_len = 8'd0;
        drive(1'b1, 1'b1, 9, 9);
        check("klen0_c_out",   u_if.c_out,   81);
        check("klen0_c_valid", u_if.c_valid, 1);
        idle();

        // Backpressure
        u_if.c_ready = 1'b0;
        u_if.k_len   = 8'd1;
        drive(1'b1, 1'b1, 2, 3);
        check("bp_c_out1",   u_if.c_out,   6);
        check("bp_err0",     u_if.err_ovf, 0);
        drive(1'b1, 1'b1, 4, 5);
        check("bp_c_out2",   u_if.c_out,   6);
        check("bp_c_valid2", u_if.c_valid, 1);
        check("bp_err1",     u_if.err_ovf, 1);
        u_if.c_ready = 1'b1;
        drive(1'b1, 1'b1, 1, 1);
        check("bp_c_out3",   u_if.c_out,   1);
        check("bp_c_valid3", u_if.c_valid, 1);
        idle();
        check("bp_c_valid4", u_if.c_valid, 0);
        check("bp_c_hold",   u_if.c_out,   1);

        // Clear mid-tile
        u_if.k_len = 8'd4;
        drive(1'b1, 1'b1, 1, 1);
        drive(1'b1, 1'b1, 1, 1);
        u_if.clear = 1'b1;
        drive(1'b1, 1'b1, 5, 5);
        u_if.clear = 1'b0;
        check("clr_busy",    u_if.busy,    0);
        check("clr_c_valid", u_if.c_valid, 0);
        check("clr_err_ovf", u_if.err_ovf, 1);
        check("clr_fwd",     u_if.a_out,   5);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1, 1);
        check("clr_cv_early", u_if.c_valid, 0);
        drive(1'b1, 1'b1, 1, 1);
        check("clr_c_out",   u_if.c_out,   4);
        check("clr_c_valid", u_if.c_valid, 1);
        idle();

        // Reset mid-tile
        drive(1'b1, 1'b1, 1, 1);
        drive(1'b1, 1'b1, 1, 1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 5, 5);
        rst = 1'b0;
        check("rst2_busy",    u_if.busy,    0);
        check("rst2_err_ovf", u_if.err_ovf, 0);
        check("rst2_c_out",   u_if.c_out,   0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1, 1);
        check("rst2_c_out4",  u_if.c_out,   4);
        check("rst2_c_valid", u_if.c_valid, 1);
        idle();

        // Accumulator overflow on the 32-bit instance
        u_if32.k_len      = 8'd3;
        u_if32.a_in       = -16'sd32768;
        u_if32.b_in       = -16'sd32768;
        u_if32.a_in_valid = 1'b1;
        u_if32.b_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        u_if32.a_in_valid = 1'b0;
        u_if32.b_in_valid = 1'b0;
        check("ovf_c_valid", u_if32.c_valid, 1);
`ifdef SYSTOLIC_PE_SATURATE_EN
        check("ovf_c_out",   u_if32.c_out,   64'sd2147483647);
        check("ovf_err_sat", u_if32.err_sat, 1);
`else
        check("ovf_c_out",   u_if32.c_out,   -64'sd1073741824);
        check("ovf_err_sat", u_if32.err_sat, 0);
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
